// File: rtl/aes_xactor_pkg.sv
// Shared types for the AES command transactor.
// Optional feature macro: AES_XACTOR_TIMEOUT_EN (bounded wait for core done pulses).
package aes_xactor_pkg;

   localparam int unsigned KEY_W_DEF   = 256;
   localparam int unsigned BLK_W_DEF   = 128;
   localparam int unsigned TIMEOUT_DEF = 64;
   localparam int unsigned CNT_W       = 8;

   typedef logic [KEY_W_DEF-1:0] key_t;
   typedef logic [BLK_W_DEF-1:0] blk_t;
   typedef logic [CNT_W-1:0]     cnt_t;

   typedef enum logic [1:0] {
      AES_NOP      = 2'b00,
      AES_LOAD_KEY = 2'b01,
      AES_ENCRYPT  = 2'b10,
      AES_DECRYPT  = 2'b11
   } aes_op_e;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_NOKEY   = 2'b01,
      ST_TIMEOUT = 2'b10
   } aes_status_e;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_KEY_GO   = 3'd1,
      S_KEY_WAIT = 3'd2,
      S_BLK_GO   = 3'd3,
      S_BLK_WAIT = 3'd4,
      S_RESP     = 3'd5
   } xact_state_e;

endpackage

// File: rtl/aes_xactor_rsp_reg.sv
// Response holding register: captures result and status, presents them on a valid/ready stage.
module aes_xactor_rsp_reg
   import aes_xactor_pkg::*;
#(
   parameter int unsigned BLK_W = BLK_W_DEF
) (
   input  logic             clk,
   input  logic             resetL,
   input  logic             load,
   input  logic [BLK_W-1:0] load_data,
   input  logic [1:0]       load_status,
   input  logic             ready,
   output logic             valid,
   output logic [BLK_W-1:0] data,
   output logic [1:0]       status
);

   // Load takes priority; data and status stay put until the next load.
   always_ff @(posedge clk or negedge resetL) begin
      if (!resetL) begin
         valid  <= 1'b0;
         data   <= '0;
         status <= ST_OK;
      end else if (load) begin
         valid  <= 1'b1;
         data   <= load_data;
         status <= load_status;
      end else if (valid && ready) begin
         valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/aes_xactor.sv
// AES command transactor: sequences key-load / encrypt / decrypt on the core.
// Optional feature macro: AES_XACTOR_TIMEOUT_EN (bounded wait, TIMEOUT status).
module aes_xactor
   import aes_xactor_pkg::*;
#(
   parameter int unsigned KEY_W   = KEY_W_DEF,
   parameter int unsigned BLK_W   = BLK_W_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             resetL,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [KEY_W-1:0] cmd_key,
   input  logic [BLK_W-1:0] cmd_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [BLK_W-1:0] rsp_data,
   output logic [1:0]       rsp_status,
   output logic [KEY_W-1:0] core_key,
   output logic             core_key_load,
   input  logic             core_key_done,
   output logic             core_start,
   output logic             core_decrypt,
   output logic [BLK_W-1:0] core_din,
   input  logic [BLK_W-1:0] core_dout,
   input  logic             core_done
);

   // The wait counter is 8 bits wide, so TIMEOUT must fit in it.
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
      $error("aes_xactor: TIMEOUT must be in 1..255");
   end

   xact_state_e      state;
   logic             key_valid;
   aes_op_e          op_c;
   logic             accept_c;
   logic             expire_c;
   logic             rsp_load_c;
   logic [BLK_W-1:0] rsp_load_data_c;
   aes_status_e      rsp_load_status_c;

   assign op_c     = aes_op_e'(cmd_op);
   assign accept_c = cmd_valid && cmd_ready;

`ifdef AES_XACTOR_TIMEOUT_EN
   cnt_t wait_cnt;

   // Cycles spent in the current wait state; cleared on the way in.
   always_ff @(posedge clk or negedge resetL) begin
      if (!resetL) begin
         wait_cnt <= '0;
      end else if (state == S_KEY_GO || state == S_BLK_GO) begin
         wait_cnt <= '0;
      end else if (state == S_KEY_WAIT || state == S_BLK_WAIT) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   assign expire_c = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
   assign expire_c = 1'b0;
`endif

   // Response load: immediate for NOP/NOKEY, else on done pulse or expiry; done beats expiry.
   always_comb begin
      rsp_load_c        = 1'b0;
      rsp_load_data_c   = '0;
      rsp_load_status_c = ST_OK;
      case (state)
         S_IDLE: begin
            if (accept_c) begin
               if (op_c == AES_NOP) begin
                  rsp_load_c = 1'b1;
               end else if ((op_c == AES_ENCRYPT || op_c == AES_DECRYPT) && !key_valid) begin
                  rsp_load_c        = 1'b1;
                  rsp_load_status_c = ST_NOKEY;
               end
            end
         end
         S_KEY_WAIT: begin
            if (core_key_done) begin
               rsp_load_c = 1'b1;
            end else if (expire_c) begin
               rsp_load_c        = 1'b1;
               rsp_load_status_c = ST_TIMEOUT;
            end
         end
         S_BLK_WAIT: begin
            if (core_done) begin
               rsp_load_c      = 1'b1;
               rsp_load_data_c = core_dout;
            end else if (expire_c) begin
               rsp_load_c        = 1'b1;
               rsp_load_status_c = ST_TIMEOUT;
            end
         end
         default: ;
      endcase
   end

   // Command FSM with registered core-side outputs and cmd_ready.
   always_ff @(posedge clk or negedge resetL) begin
      if (!resetL) begin
         state         <= S_IDLE;
         cmd_ready     <= 1'b1;
         key_valid     <= 1'b0;
         core_key      <= '0;
         core_din      <= '0;
         core_decrypt  <= 1'b0;
         core_key_load <= 1'b0;
         core_start    <= 1'b0;
      end else begin
         core_key_load <= 1'b0;
         core_start    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept_c) begin
                  core_key     <= cmd_key;
                  core_din     <= cmd_data;
                  core_decrypt <= (op_c == AES_DECRYPT);
                  cmd_ready    <= 1'b0;
                  case (op_c)
                     AES_LOAD_KEY: begin
                        state         <= S_KEY_GO;
                        core_key_load <= 1'b1;
                     end
                     AES_ENCRYPT, AES_DECRYPT: begin
                        if (key_valid) begin
                           state      <= S_BLK_GO;
                           core_start <= 1'b1;
                        end else begin
                           state <= S_RESP;
                        end
                     end
                     default: state <= S_RESP;
                  endcase
               end
            end
            S_KEY_GO: begin
               key_valid <= 1'b0;
               state     <= S_KEY_WAIT;
            end
            S_KEY_WAIT: begin
               if (core_key_done) begin
                  key_valid <= 1'b1;
                  state     <= S_RESP;
               end else if (expire_c) begin
                  state <= S_RESP;
               end
            end
            S_BLK_GO: begin
               state <= S_BLK_WAIT;
            end
            S_BLK_WAIT: begin
               if (core_done || expire_c) begin
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  cmd_ready <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   aes_xactor_rsp_reg #(
      .BLK_W (BLK_W)
   ) u_rsp_reg (
      .clk         (clk),
      .resetL      (resetL),
      .load        (rsp_load_c),
      .load_data   (rsp_load_data_c),
      .load_status (rsp_load_status_c),
      .ready       (rsp_ready),
      .valid       (rsp_valid),
      .data        (rsp_data),
      .status      (rsp_status)
   );

endmodule

// File: tb/tb_aes_xactor.sv
// Self-checking bench for aes_xactor: transaction-level model + per-cycle compare + directed vectors.
// Timeout scenarios run only when AES_XACTOR_TIMEOUT_EN is defined.
module tb_aes_xactor;

   localparam int unsigned TO = 64;
`ifdef AES_XACTOR_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   localparam logic [255:0] KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] JUNK = 128'hdeadbeef_cafef00d_0badc0de_5a5a5a5a;

   logic         clk = 1'b0;
   logic         resetL = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op = 2'b00;
   logic [255:0] cmd_key = '0;
   logic [127:0] cmd_data = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b1;
   logic [127:0] rsp_data;
   logic [1:0]   rsp_status;
   logic [255:0] core_key;
   logic         core_key_load;
   logic         core_key_done = 1'b0;
   logic         core_start;
   logic         core_decrypt;
   logic [127:0] core_din;
   logic [127:0] core_dout = JUNK;
   logic         core_done = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   aes_xactor dut (
      .clk           (clk),
      .resetL        (resetL),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_key       (cmd_key),
      .cmd_data      (cmd_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_status    (rsp_status),
      .core_key      (core_key),
      .core_key_load (core_key_load),
      .core_key_done (core_key_done),
      .core_start    (core_start),
      .core_decrypt  (core_decrypt),
      .core_din      (core_din),
      .core_dout     (core_dout),
      .core_done     (core_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
   endtask

   // ---------------- transaction-level model ----------------
   // busy: a command is outstanding until its response is taken by the host.
   bit           m_busy, m_have_key, m_wait, m_wait_key;
   int           m_waited;
   logic         e_rsp_valid, e_key_load, e_start, e_decrypt;
   logic [127:0] e_rsp_data, e_din;
   logic [255:0] e_key;
   logic [1:0]   e_status;

   always @(posedge clk or negedge resetL) begin
      if (!resetL) begin
         m_busy = 0; m_have_key = 0; m_wait = 0; m_wait_key = 0; m_waited = 0;
         e_rsp_valid = 0; e_key_load = 0; e_start = 0; e_decrypt = 0;
         e_rsp_data = '0; e_din = '0; e_key = '0; e_status = 2'b00;
      end else if (e_rsp_valid) begin
         if (rsp_ready) begin
            e_rsp_valid = 0;
            m_busy = 0;
         end
      end else if (!m_busy) begin
         if (cmd_valid) begin
            m_busy    = 1;
            e_key     = cmd_key;
            e_din     = cmd_data;
            e_decrypt = (cmd_op == 2'b11);
            if (cmd_op == 2'b00) begin
               e_rsp_valid = 1; e_rsp_data = '0; e_status = 2'b00;
            end else if (cmd_op == 2'b01) begin
               m_have_key = 0; e_key_load = 1; m_wait_key = 1;
            end else if (m_have_key) begin
               e_start = 1; m_wait_key = 0;
            end else begin
               e_rsp_valid = 1; e_rsp_data = '0; e_status = 2'b01;
            end
         end
      end else if (e_key_load || e_start) begin
         e_key_load = 0; e_start = 0;
         m_wait = 1; m_waited = 0;
      end else if (m_wait) begin
         if (m_wait_key ? core_key_done : core_done) begin
            m_wait = 0;
            if (m_wait_key) m_have_key = 1;
            e_rsp_valid = 1;
            e_rsp_data  = m_wait_key ? 128'h0 : core_dout;
            e_status    = 2'b00;
         end else begin
            m_waited++;
            if (TO_EN && m_waited == TO) begin
               m_wait = 0;
               e_rsp_valid = 1; e_rsp_data = '0; e_status = 2'b10;
            end
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmd_ready",     256'(cmd_ready),     256'(!m_busy));
         chk("rsp_valid",     256'(rsp_valid),     256'(e_rsp_valid));
         chk("core_key_load", 256'(core_key_load), 256'(e_key_load));
         chk("core_start",    256'(core_start),    256'(e_start));
         chk("core_decrypt",  256'(core_decrypt),  256'(e_decrypt));
         chk("core_din",      256'(core_din),      256'(e_din));
         chk("core_key",      core_key,            e_key);
         if (e_rsp_valid) begin
            chk("rsp_data",   256'(rsp_data),   256'(e_rsp_data));
            chk("rsp_status", 256'(rsp_status), 256'(e_status));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic send(input logic [1:0] op, input logic [255:0] key, input logic [127:0] data,
                       output int t0);
      cmd_op = op; cmd_key = key; cmd_data = data; cmd_valid = 1'b1;
      t0 = -1;
      for (int n = 0; n < 300; n++) begin
         if (cmd_ready === 1'b1) begin
            t0 = cyc;
            tick();
            break;
         end
         tick();
      end
      cmd_valid = 1'b0;
      if (t0 < 0) fail_bound("accept");
   endtask

   task automatic wait_rsp(output int t);
      t = -1;
      for (int n = 0; n < 300; n++) begin
         if (rsp_valid === 1'b1) begin
            t = cyc;
            break;
         end
         tick();
      end
      if (t < 0) fail_bound("rsp_valid");
   endtask

   task automatic done_at(input int c, input bit is_key, input logic [127:0] dout);
      wait_until(c);
      if (is_key) core_key_done = 1'b1;
      else begin
         core_done = 1'b1;
         core_dout = dout;
      end
      tick();
      core_key_done = 1'b0;
      core_done = 1'b0;
      core_dout = JUNK;
   endtask

   task automatic load_key(input int lat);
      int t0, t;
      send(2'b01, KEY, JUNK, t0);
      done_at(t0 + 1 + lat, 1'b1, JUNK);
      wait_rsp(t);
      chk("load_key_status", 256'(rsp_status), 256'(2'b00));
      tick();
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int t0, t;
      logic [127:0] held;
      repeat (3) tick();
      chk_en = 1'b1;
      chk("reset_cmd_ready", 256'(cmd_ready), 256'(1'b1));
      chk("reset_rsp_valid", 256'(rsp_valid), 256'(1'b0));
      chk("reset_core_key",  core_key,        256'h0);
      resetL = 1'b1;
      tick();

      // ENCRYPT with no key: NOKEY in T1, core never started.
      send(2'b10, '0, PT, t0);
      chk("nokey_rsp_t1",       256'(rsp_valid),  256'(1'b1));
      chk("nokey_status",       256'(rsp_status), 256'(2'b01));
      chk("nokey_data",         256'(rsp_data),   256'h0);
      chk("nokey_no_start",     256'(core_start), 256'(1'b0));
      chk("model_nokey_status", 256'(e_status),   256'(2'b01));
      tick();

      // Stray done pulses in IDLE are ignored.
      core_done = 1'b1; core_key_done = 1'b1; core_dout = CT;
      tick();
      core_done = 1'b0; core_key_done = 1'b0; core_dout = JUNK;
      tick();
      chk("stray_done_ignored", 256'(rsp_valid), 256'(1'b0));

      // LOAD_KEY: pulse in T1, key_done 10 cycles after the pulse, response in T12.
      send(2'b01, KEY, JUNK, t0);
      chk("key_load_t1", 256'(core_key_load), 256'(1'b1));
      chk("core_key_t1", core_key, KEY);
      tick();
      chk("key_load_one_cycle", 256'(core_key_load), 256'(1'b0));
      core_done = 1'b1;                       // wrong done in KEY_WAIT: ignored
      tick();
      core_done = 1'b0;
      done_at(t0 + 11, 1'b1, JUNK);
      wait_rsp(t);
      chk("key_rsp_cycle", 256'(t - t0), 256'(12));
      chk("key_status",    256'(rsp_status), 256'(2'b00));
      tick();

      // ENCRYPT: core latency 5 -> response 7 cycles after accept.
      send(2'b10, '0, PT, t0);
      chk("enc_start_t1", 256'(core_start),   256'(1'b1));
      chk("enc_decrypt",  256'(core_decrypt), 256'(1'b0));
      chk("enc_din",      256'(core_din),     256'(PT));
      done_at(t0 + 6, 1'b0, CT);
      wait_rsp(t);
      chk("enc_rsp_cycle", 256'(t - t0), 256'(7));
      chk("enc_data",      256'(rsp_data), 256'(CT));
      chk("model_enc_data", 256'(e_rsp_data), 256'(CT));
      tick();

      // DECRYPT of the ciphertext.
      send(2'b11, '0, CT, t0);
      chk("dec_decrypt", 256'(core_decrypt), 256'(1'b1));
      done_at(t0 + 4, 1'b0, PT);
      chk("dec_decrypt_held", 256'(core_decrypt), 256'(1'b1));
      wait_rsp(t);
      chk("dec_data", 256'(rsp_data), 256'(PT));
      tick();

      // Back-to-back NOPs: second accept two cycles after the first.
      send(2'b00, '0, '0, t0);
      send(2'b00, '0, '0, t);
      chk("b2b_accept_gap", 256'(t - t0), 256'(2));
      tick();

      // Response stall with cmd_valid held high.
      rsp_ready = 1'b0;
      send(2'b10, '0, PT, t0);
      cmd_op = 2'b00; cmd_valid = 1'b1;
      done_at(t0 + 3, 1'b0, CT);
      wait_rsp(t);
      held = rsp_data;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid",     256'(rsp_valid),  256'(1'b1));
         chk("stall_data",      256'(rsp_data),   256'(CT));
         chk("stall_status",    256'(rsp_status), 256'(2'b00));
         chk("stall_cmd_ready", 256'(cmd_ready),  256'(1'b0));
         tick();
      end
      chk("stall_held", 256'(rsp_data), 256'(held));
      rsp_ready = 1'b1;
      tick();                                 // handshake cycle ends; IDLE accepts the held NOP
      tick();
      chk("held_nop_rsp", 256'(rsp_valid), 256'(1'b1));
      cmd_valid = 1'b0;
      tick();
      tick();

`ifdef AES_XACTOR_TIMEOUT_EN
      // Block timeout: BLK_WAIT entered in T2, TIMEOUT response in T66.
      send(2'b10, '0, PT, t0);
      wait_rsp(t);
      chk("blk_timeout_cycle",  256'(t - t0), 256'(66));
      chk("blk_timeout_status", 256'(rsp_status), 256'(2'b10));
      chk("blk_timeout_data",   256'(rsp_data), 256'h0);
      tick();

      // Done in the expiry cycle wins.
      send(2'b10, '0, PT, t0);
      done_at(t0 + 65, 1'b0, CT);
      wait_rsp(t);
      chk("expiry_done_cycle",  256'(t - t0), 256'(66));
      chk("expiry_done_status", 256'(rsp_status), 256'(2'b00));
      chk("expiry_done_data",   256'(rsp_data), 256'(CT));
      tick();

      // Key timeout leaves no valid key.
      send(2'b01, KEY, JUNK, t0);
      wait_rsp(t);
      chk("key_timeout_status", 256'(rsp_status), 256'(2'b10));
      tick();
      send(2'b10, '0, PT, t0);
      chk("after_key_timeout_nokey", 256'(rsp_status), 256'(2'b01));
      tick();
      load_key(3);
`else
      // Without the timeout feature the wait is unbounded.
      send(2'b10, '0, PT, t0);
      repeat (100) tick();
      chk("no_timeout_still_waiting", 256'(rsp_valid), 256'(1'b0));
      done_at(cyc, 1'b0, CT);
      wait_rsp(t);
      chk("late_done_status", 256'(rsp_status), 256'(2'b00));
      chk("late_done_data",   256'(rsp_data), 256'(CT));
      tick();
`endif

      // Reset while in BLK_WAIT aborts and drops the key.
      send(2'b10, '0, PT, t0);
      tick();
      tick();
      resetL = 1'b0;
      #1;
      chk("abort_cmd_ready", 256'(cmd_ready),    256'(1'b1));
      chk("abort_rsp_valid", 256'(rsp_valid),    256'(1'b0));
      chk("abort_core_din",  256'(core_din),     256'h0);
      chk("abort_start",     256'(core_start),   256'(1'b0));
      tick();
      resetL = 1'b1;
      tick();
      send(2'b10, '0, PT, t0);
      chk("post_reset_nokey", 256'(rsp_status), 256'(2'b01));
      chk("post_reset_valid", 256'(rsp_valid),  256'(1'b1));
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
